updown_mod_counter_n: RTL and testbench

Parametrised up/down modulo counter with four-mode control (clear / load / run / hold) for board display and timing paths.
- Generalises the team's fixed 0..99 counter: configurable width, modulus, load presets and run-rate prescaler, plus an external load value.
- Rollover is reported as a one-cycle pulse and as a sticky, software-clearable flag.
- Sits between the mode-control FSM and the display/BCD logic.

---
 rtl/updown_mod_counter_n.sv | 123 ++++++++++++
 tb/tb_updown_mod_counter_n.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter_n.sv
// rtl/updown_mod_counter_n.sv - parametrised up/down modulo counter with clear/load/run/hold modes
// Rollover is reported as a one-cycle pulse and a sticky flag cleared by roll_clr.
module updown_mod_counter_n #(
  parameter int WIDTH     = 7,
  parameter int MAX_COUNT = 99,
  parameter int UP_LOAD   = 90,
  parameter int DN_LOAD   = 10,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ud,
  input  logic [1:0]       state,
  input  logic             load_ext,
  input  logic [WIDTH-1:0] load_val,
  input  logic             roll_clr,
  output logic [WIDTH-1:0] count,
  output logic             roll,
  output logic             roll_sticky,
  output logic             tc
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] UP_C    = WIDTH'(UP_LOAD);
  localparam logic [WIDTH-1:0] DN_C    = WIDTH'(DN_LOAD);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;

  generate
    if ((2 ** WIDTH) <= MAX_COUNT) begin : g_bad_width
      $error("updown_mod_counter_n: WIDTH too small for MAX_COUNT");
    end
    if (UP_LOAD > MAX_COUNT || DN_LOAD > MAX_COUNT) begin : g_bad_preset
      $error("updown_mod_counter_n: load preset exceeds MAX_COUNT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("updown_mod_counter_n: PRESCALE must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  pre_q, pre_d;
  logic             roll_q, roll_d;
  logic             sticky_q, sticky_d;
  logic             wrap;

  always_comb begin
    count_d  = count_q;
    pre_d    = pre_q;
    wrap     = 1'b0;

    case (state)
      MODE_CLEAR: begin
        count_d = ud ? '0 : MAX_C;
        pre_d   = '0;
      end
      MODE_LOAD: begin
        if (load_ext) begin
          count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else begin
          count_d = ud ? UP_C : DN_C;
        end
        pre_d = '0;
      end
      MODE_RUN: begin
        if (pre_q == PS_LAST) begin
          pre_d = '0;
          // An out-of-range count (e.g. after an upset) is pulled back silently.
          if (count_q > MAX_C) begin
            count_d = ud ? '0 : MAX_C;
          end else if (ud) begin
            if (count_q == MAX_C) begin
              count_d = '0;
              wrap    = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            if (count_q == '0) begin
              count_d = MAX_C;
              wrap    = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end else begin
          pre_d = pre_q + PS_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Guarantees a single-cycle pulse even for the degenerate MAX_COUNT=0 case.
    roll_d   = wrap & ~roll_q;
    sticky_d = wrap | (sticky_q & ~roll_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      pre_q    <= '0;
      roll_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      pre_q    <= pre_d;
      roll_q   <= roll_d;
      sticky_q <= sticky_d;
    end
  end

  assign count       = count_q;
  assign roll        = roll_q;
  assign roll_sticky = sticky_q;
  assign tc          = (state == MODE_RUN) && (ud ? (count_q == MAX_C) : (count_q == '0));

endmodule

// File: tb/tb_updown_mod_counter_n.sv
// tb/tb_updown_mod_counter_n.sv - directed self-checking bench for updown_mod_counter_n
module tb_updown_mod_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       ud;
  logic [1:0] state;
  logic       load_ext;
  logic [6:0] load_val;
  logic       roll_clr;

  logic [6:0] count;
  logic       roll, roll_sticky, tc;
  logic [6:0] count4;
  logic       roll4, roll_sticky4, tc4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter_n dut (
    .clk(clk), .rst(rst), .ud(ud), .state(state), .load_ext(load_ext),
    .load_val(load_val), .roll_clr(roll_clr),
    .count(count), .roll(roll), .roll_sticky(roll_sticky), .tc(tc)
  );

  updown_mod_counter_n #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .ud(ud), .state(state), .load_ext(load_ext),
    .load_val(load_val), .roll_clr(roll_clr),
    .count(count4), .roll(roll4), .roll_sticky(roll_sticky4), .tc(tc4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ud = 1'b1; state = 2'b11; load_ext = 1'b0; load_val = '0; roll_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (count !== 7'd0 || roll !== 1'b0 || roll_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_state count=%0d roll=%0b sticky=%0b required 0/0/0", count, roll, roll_sticky);
    end
    // build up state: a wrap to set sticky, then park at 57
    state = 2'b01; load_ext = 1'b1; load_val = 7'd99; tick();
    state = 2'b10; tick();
    state = 2'b01; load_val = 7'd57; tick();
    state = 2'b11;
    checks++;
    if (count !== 7'd57 || roll_sticky !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset count=%0d sticky=%0b required 57/1", count, roll_sticky);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (count !== 7'd0 || roll !== 1'b0 || roll_sticky !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d roll=%0b sticky=%0b required 0/0/0", count, roll, roll_sticky);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 7'd0 || roll_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_held count=%0d sticky=%0b required 0/0", count, roll_sticky);
    end
    load_ext = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [6:0] exp;
    ud = 1'b1; state = 2'b01; load_ext = 1'b0; tick();
    checks++;
    if (count !== 7'd90) begin
      failures++;
      $display("FAIL up_preset count=%0d required 90", count);
    end
    state = 2'b10;
    exp = 7'd90;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = (exp == 7'd99) ? 7'd0 : exp + 7'd1;
      checks++;
      if (count !== exp || roll !== (i == 10) || tc !== (exp == 7'd99)) begin
        failures++;
        $display("FAIL up_run step=%0d count=%0d roll=%0b tc=%0b required %0d/%0b/%0b",
                 i, count, roll, tc, exp, (i == 10), (exp == 7'd99));
      end
    end
    tick();
    checks++;
    if (count !== 7'd1 || roll !== 1'b0 || roll_sticky !== 1'b1) begin
      failures++;
      $display("FAIL up_after_wrap count=%0d roll=%0b sticky=%0b required 1/0/1", count, roll, roll_sticky);
    end
  endtask

  task automatic test_down_wrap_hold();
    logic [6:0] exp;
    ud = 1'b0; state = 2'b00; tick();
    checks++;
    if (count !== 7'd99 || roll_sticky !== 1'b1) begin
      failures++;
      $display("FAIL down_clear count=%0d sticky=%0b required 99/1", count, roll_sticky);
    end
    state = 2'b01; tick();
    checks++;
    if (count !== 7'd10 || tc !== 1'b0) begin
      failures++;
      $display("FAIL down_preset count=%0d tc=%0b required 10/0", count, tc);
    end
    state = 2'b10;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp = (i == 11) ? 7'd99 : 7'(10 - i);
      checks++;
      if (count !== exp || roll !== (i == 11) || tc !== (exp == 7'd0)) begin
        failures++;
        $display("FAIL down_run step=%0d count=%0d roll=%0b tc=%0b required %0d/%0b/%0b",
                 i, count, roll, tc, exp, (i == 11), (exp == 7'd0));
      end
    end
    state = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (count !== 7'd99 || roll !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle=%0d count=%0d roll=%0b required 99/0", i, count, roll);
      end
    end
  endtask

  task automatic test_ext_load_dir_change();
    ud = 1'b1; state = 2'b01; load_ext = 1'b1; load_val = 7'd120; tick();
    checks++;
    if (count !== 7'd99) begin
      failures++;
      $display("FAIL load_saturate count=%0d required 99", count);
    end
    load_val = 7'd42; tick();
    checks++;
    if (count !== 7'd42) begin
      failures++;
      $display("FAIL load_ext count=%0d required 42", count);
    end
    load_val = 7'd50; tick();
    state = 2'b10; load_ext = 1'b0; tick();
    checks++;
    if (count !== 7'd51) begin
      failures++;
      $display("FAIL dir_up count=%0d required 51", count);
    end
    ud = 1'b0; tick();
    checks++;
    if (count !== 7'd50) begin
      failures++;
      $display("FAIL dir_change count=%0d required 50", count);
    end
    tick();
    checks++;
    if (count !== 7'd49) begin
      failures++;
      $display("FAIL dir_down count=%0d required 49", count);
    end
  endtask

  task automatic test_prescale();
    ud = 1'b1; state = 2'b00; tick();
    state = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (count4 !== ((i == 4) ? 7'd1 : 7'd0)) begin
        failures++;
        $display("FAIL prescale_run clk=%0d count=%0d required %0d", i, count4, (i == 4) ? 1 : 0);
      end
    end
    tick(); tick();
    state = 2'b11;
    tick(); tick(); tick();
    checks++;
    if (count4 !== 7'd1) begin
      failures++;
      $display("FAIL prescale_hold count=%0d required 1", count4);
    end
    state = 2'b10; tick();
    checks++;
    if (count4 !== 7'd1) begin
      failures++;
      $display("FAIL prescale_phase_a count=%0d required 1", count4);
    end
    tick();
    checks++;
    if (count4 !== 7'd2) begin
      failures++;
      $display("FAIL prescale_phase_b count=%0d required 2", count4);
    end
    tick(); tick(); tick();
    checks++;
    if (count4 !== 7'd2) begin
      failures++;
      $display("FAIL prescale_gap count=%0d required 2", count4);
    end
    tick();
    checks++;
    if (count4 !== 7'd3) begin
      failures++;
      $display("FAIL prescale_next count=%0d required 3", count4);
    end
  endtask

  task automatic test_sticky_clear();
    state = 2'b11; roll_clr = 1'b1; tick();
    checks++;
    if (roll_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clr sticky=%0b required 0", roll_sticky);
    end
    roll_clr = 1'b0; ud = 1'b1; state = 2'b01; load_ext = 1'b1; load_val = 7'd99; tick();
    load_ext = 1'b0; state = 2'b10; roll_clr = 1'b1; tick();
    checks++;
    if (count !== 7'd0 || roll !== 1'b1 || roll_sticky !== 1'b1) begin
      failures++;
      $display("FAIL set_wins count=%0d roll=%0b sticky=%0b required 0/1/1", count, roll, roll_sticky);
    end
    state = 2'b11; tick();
    checks++;
    if (roll !== 1'b0 || roll_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clr_next roll=%0b sticky=%0b required 0/0", roll, roll_sticky);
    end
    roll_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap_hold();
    test_ext_load_dir_change();
    test_prescale();
    test_sticky_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
